config_commit_bank: RTL and testbench

- Sits directly downstream of the global configuration splitter's per-consumer shift-register stage.
- Consumes one configuration write stream (addr/data/valid, no backpressure) and decodes it into N_REGS shadow registers.
- On a commit write, atomically copies all shadow registers to the active set and offers them to the consuming datapath through a valid/ready handshake.
- Active values never change while an offer is outstanding.

---
 rtl/config_commit_bank.sv | 119 +++++++++++
 tb/tb_config_commit_bank.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/config_commit_bank.sv
// config_commit_bank: decodes a config write stream into shadow registers and,
// on a commit write, atomically publishes them as the active set through a
// valid/ready offer. Commits that arrive while an offer is pending are queued.
// At most one commit can be queued; any further ones are merged into it and
// counted as drops.
module config_commit_bank #(
    parameter int N_REGS    = 8,
    parameter int DATA_BITS = 64,
    parameter int ADDR_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_BITS-1:0]        cfg_addr,
    input  logic [DATA_BITS-1:0]        cfg_data,
    input  logic                        cfg_valid,
    output logic [N_REGS*DATA_BITS-1:0] act_regs,
    output logic                        act_valid,
    input  logic                        act_ready,
    output logic [31:0]                 commit_count,
    output logic [15:0]                 drop_count
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t               state;
    logic                 queued;
    logic [DATA_BITS-1:0] shadow [N_REGS];
    logic [DATA_BITS-1:0] active [N_REGS];

    logic commit;
    logic clear_drops;
    logic handshake;
    logic drop_event;

    // Decode of the special addresses directly above the register window
    always_comb begin
        commit      = cfg_valid && (cfg_addr == ADDR_BITS'(N_REGS));
        clear_drops = cfg_valid && (cfg_addr == ADDR_BITS'(N_REGS + 1));
        handshake   = act_valid && act_ready;
        // A commit that finds one already queued merges into it,
        // whether or not a handshake happens in the same cycle
        drop_event  = commit && (state == OFFER) && queued;
    end

    // Shadow register writes are accepted in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '{default: '0};
        end else if (cfg_valid) begin
            for (int unsigned i = 0; i < N_REGS; i++) begin
                if (cfg_addr == ADDR_BITS'(i)) begin
                    shadow[i] <= cfg_data;
                end
            end
        end
    end

    // Offer FSM: active set, act_valid, queued commit and commit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            act_valid    <= 1'b0;
            queued       <= 1'b0;
            active       <= '{default: '0};
            commit_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (commit) begin
                        active    <= shadow;
                        act_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (handshake) begin
                        commit_count <= commit_count + 32'd1;
                        if (commit || queued) begin
                            // A queued commit takes the shadow contents at
                            // handshake time, so it and a new commit copy the same set
                            active <= shadow;
                            queued <= 1'b0;
                        end else begin
                            act_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (commit) begin
                        queued <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    act_valid <= 1'b0;
                end
            endcase
        end
    end

    // Drop counter: clear has priority over a coincident drop, saturates at max
    always_ff @(posedge clk) begin
        if (rst || clear_drops) begin
            drop_count <= '0;
        end else if (drop_event && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // Flatten the active set onto the output bus
    always_comb begin
        act_regs = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            act_regs[i*DATA_BITS +: DATA_BITS] = active[i];
        end
    end

endmodule

// File: tb/tb_config_commit_bank.sv
// Testbench for config_commit_bank: table-driven vectors plus hand-written
// multi-cycle sequences for queueing, coalescing and reset.
module tb_config_commit_bank;

    localparam int N_REGS    = 8;
    localparam int DATA_BITS = 64;
    localparam int ADDR_BITS = 8;

    localparam logic [7:0] A_COMMIT = 8'd8;
    localparam logic [7:0] A_CLEAR  = 8'd9;
    localparam logic [7:0] A_BAD    = 8'd13;

    logic                        clk;
    logic                        rst;
    logic [ADDR_BITS-1:0]        cfg_addr;
    logic [DATA_BITS-1:0]        cfg_data;
    logic                        cfg_valid;
    logic [N_REGS*DATA_BITS-1:0] act_regs;
    logic                        act_valid;
    logic                        act_ready;
    logic [31:0]                 commit_count;
    logic [15:0]                 drop_count;

    int vectors;
    int miscompares;

    config_commit_bank #(
        .N_REGS   (N_REGS),
        .DATA_BITS(DATA_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .act_regs    (act_regs),
        .act_valid   (act_valid),
        .act_ready   (act_ready),
        .commit_count(commit_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [7:0]  addr;
        logic [63:0] data;
        logic        valid;
        logic        ready;
        logic        e_av;
        int          idx;
        logic [63:0] e_reg;
        logic [31:0] e_cc;
        logic [15:0] e_dc;
    } vec_t;

    vec_t vecs[10];

    // Drive one cycle of inputs, then check outputs 1 time unit after the edge
    task automatic step(input logic r, input logic [7:0] a, input logic [63:0] d,
                        input logic v, input logic rdy, input logic e_av, input int idx,
                        input logic [63:0] e_reg, input logic [31:0] e_cc,
                        input logic [15:0] e_dc);
        logic [63:0] got;
        rst       = r;
        cfg_addr  = a;
        cfg_data  = d;
        cfg_valid = v;
        act_ready = rdy;
        @(posedge clk);
        #1;
        vectors++;
        got = act_regs[idx*DATA_BITS +: DATA_BITS];
        if (act_valid !== e_av) begin
            miscompares++;
            $display("FAIL vec%0d act_valid got %0b want %0b", vectors, act_valid, e_av);
        end
        if (got !== e_reg) begin
            miscompares++;
            $display("FAIL vec%0d act_regs[%0d] got %h want %h", vectors, idx, got, e_reg);
        end
        if (commit_count !== e_cc) begin
            miscompares++;
            $display("FAIL vec%0d commit_count got %0d want %0d", vectors, commit_count, e_cc);
        end
        if (drop_count !== e_dc) begin
            miscompares++;
            $display("FAIL vec%0d drop_count got %0d want %0d", vectors, drop_count, e_dc);
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        cfg_addr    = '0;
        cfg_data    = '0;
        cfg_valid   = 1'b0;
        act_ready   = 1'b0;
        vectors     = 0;
        miscompares = 0;

        //          rst   addr      data     vld   rdy   av  idx reg       cc  dc
        vecs[0] = '{1'b1, 8'd0,     64'h0,   1'b0, 1'b0, 1'b0, 0, 64'h0,  32'd0, 16'd0};
        vecs[1] = '{1'b0, 8'd0,     64'h11,  1'b1, 1'b1, 1'b0, 0, 64'h0,  32'd0, 16'd0};
        vecs[2] = '{1'b0, 8'd1,     64'h22,  1'b1, 1'b1, 1'b0, 1, 64'h0,  32'd0, 16'd0};
        vecs[3] = '{1'b0, A_COMMIT, 64'h0,   1'b1, 1'b1, 1'b1, 0, 64'h11, 32'd0, 16'd0};
        vecs[4] = '{1'b0, 8'd0,     64'h0,   1'b0, 1'b1, 1'b0, 1, 64'h22, 32'd1, 16'd0};
        vecs[5] = '{1'b0, A_COMMIT, 64'h0,   1'b1, 1'b0, 1'b1, 0, 64'h11, 32'd1, 16'd0};
        vecs[6] = '{1'b0, 8'd0,     64'hAA,  1'b1, 1'b0, 1'b1, 0, 64'h11, 32'd1, 16'd0};
        vecs[7] = '{1'b0, 8'd0,     64'h0,   1'b0, 1'b1, 1'b0, 0, 64'h11, 32'd2, 16'd0};
        vecs[8] = '{1'b0, A_COMMIT, 64'h0,   1'b1, 1'b0, 1'b1, 0, 64'hAA, 32'd2, 16'd0};
        vecs[9] = '{1'b0, 8'd0,     64'h0,   1'b0, 1'b1, 1'b0, 0, 64'hAA, 32'd3, 16'd0};

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].addr, vecs[i].data, vecs[i].valid, vecs[i].ready,
                 vecs[i].e_av, vecs[i].idx, vecs[i].e_reg, vecs[i].e_cc, vecs[i].e_dc);
        end

        // Queue and coalesce: shadow[2] = 1, 2, 3 before each of three commits
        step(0, 8'd2,     64'd1, 1, 0, 0, 2, 64'd0, 32'd3, 16'd0);
        step(0, A_COMMIT, 64'd0, 1, 0, 1, 2, 64'd1, 32'd3, 16'd0);
        step(0, 8'd2,     64'd2, 1, 0, 1, 2, 64'd1, 32'd3, 16'd0);
        step(0, A_COMMIT, 64'd0, 1, 0, 1, 2, 64'd1, 32'd3, 16'd0);
        step(0, 8'd2,     64'd3, 1, 0, 1, 2, 64'd1, 32'd3, 16'd0);
        step(0, A_COMMIT, 64'd0, 1, 0, 1, 2, 64'd1, 32'd3, 16'd1);
        step(0, 8'd0,     64'd0, 0, 1, 1, 2, 64'd3, 32'd4, 16'd1);
        step(0, 8'd0,     64'd0, 0, 0, 1, 2, 64'd3, 32'd4, 16'd1);
        step(0, 8'd0,     64'd0, 0, 1, 0, 2, 64'd3, 32'd5, 16'd1);

        // Commit coincident with handshake while a commit is queued
        step(0, A_COMMIT, 64'd0, 1, 0, 1, 2, 64'd3, 32'd5, 16'd1);
        step(0, A_COMMIT, 64'd0, 1, 0, 1, 2, 64'd3, 32'd5, 16'd1);
        step(0, 8'd2,     64'd4, 1, 0, 1, 2, 64'd3, 32'd5, 16'd1);
        step(0, A_COMMIT, 64'd0, 1, 1, 1, 2, 64'd4, 32'd6, 16'd2);
        step(0, 8'd0,     64'd0, 0, 1, 0, 2, 64'd4, 32'd7, 16'd2);

        // Out-of-range write is ignored; slot 5 (13 mod 8) must stay zero
        step(0, A_BAD,    64'hDEAD, 1, 0, 0, 2, 64'd4, 32'd7, 16'd2);
        step(0, A_COMMIT, 64'd0,    1, 0, 1, 5, 64'd0, 32'd7, 16'd2);
        step(0, A_COMMIT, 64'd0,    1, 0, 1, 0, 64'hAA, 32'd7, 16'd2);
        step(0, A_COMMIT, 64'd0,    1, 0, 1, 0, 64'hAA, 32'd7, 16'd3);
        step(0, A_CLEAR,  64'd0,    1, 0, 1, 0, 64'hAA, 32'd7, 16'd0);
        step(0, A_COMMIT, 64'd0,    1, 0, 1, 0, 64'hAA, 32'd7, 16'd1);
        step(0, A_CLEAR,  64'd0,    1, 0, 1, 0, 64'hAA, 32'd7, 16'd0);

        // Reset mid-offer with a queued commit
        step(1, 8'd0, 64'd0, 0, 0, 0, 0, 64'd0, 32'd0, 16'd0);
        for (int i = 0; i < N_REGS; i++) begin
            vectors++;
            if (act_regs[i*DATA_BITS +: DATA_BITS] !== 64'd0) begin
                miscompares++;
                $display("FAIL reset act_regs[%0d] got %h want 0", i,
                         act_regs[i*DATA_BITS +: DATA_BITS]);
            end
        end
        step(0, 8'd0,     64'h11, 1, 1, 0, 0, 64'h0,  32'd0, 16'd0);
        step(0, 8'd1,     64'h22, 1, 1, 0, 1, 64'h0,  32'd0, 16'd0);
        step(0, A_COMMIT, 64'h0,  1, 1, 1, 0, 64'h11, 32'd0, 16'd0);
        step(0, 8'd0,     64'h0,  0, 1, 0, 1, 64'h22, 32'd1, 16'd0);
        // shadow[2] was cleared by reset, so the new set has slot 2 = 0
        step(0, A_COMMIT, 64'h0,  1, 0, 1, 2, 64'h0,  32'd1, 16'd0);
        step(0, 8'd0,     64'h0,  0, 1, 0, 2, 64'h0,  32'd2, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
